// File: rtl/ibex_clkgate_ctrl.sv
// ibex_clkgate_ctrl: sequences the enable of a clock gating cell shared by
// several requesters. The gate opens on any request, acks once the gated clock
// is guaranteed running, and closes after an idle hysteresis.
// Optional gated-cycle statistics counter: define CLKGATE_STATS_EN.
module ibex_clkgate_ctrl #(
    parameter int unsigned NumReq     = 4,
    parameter int unsigned WakeCycles = 2,
    parameter int unsigned IdleCycles = 8
`ifdef CLKGATE_STATS_EN
    ,
    parameter int unsigned CntW       = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    output logic [NumReq-1:0] ack_o,
    input  logic              test_en_i,
    output logic              en_o,
    output logic              active_o
`ifdef CLKGATE_STATS_EN
    ,
    input  logic              stats_clr_i,
    output logic [CntW-1:0]   gated_cycles_o
`endif
);

    localparam int unsigned WakeW = (WakeCycles > 0) ? $clog2(WakeCycles + 1) : 1;
    localparam int unsigned IdleW = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;

    // Counter reload values; the zero-cycle cases never load them.
    localparam logic [WakeW-1:0] WakeLoad = WakeW'((WakeCycles > 0) ? WakeCycles - 1 : 0);
    localparam logic [IdleW-1:0] IdleLoad = IdleW'((IdleCycles > 0) ? IdleCycles - 1 : 0);

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StWake = 2'd1,
        StOn   = 2'd2,
        StIdle = 2'd3
    } state_e;

    state_e           state_q;
    logic             en_q;
    logic [WakeW-1:0] wake_cnt_q;
    logic [IdleW-1:0] idle_cnt_q;
    logic             any_req;

    // DFT force-on counts as one more requester.
    assign any_req = (|req_i) | test_en_i;

    // Gate sequencing: OFF -> WAKE -> ON <-> IDLE -> OFF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StOff;
            en_q       <= 1'b0;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (any_req) begin
                        en_q <= 1'b1;
                        if (WakeCycles == 0) begin
                            state_q <= StOn;
                        end else begin
                            state_q    <= StWake;
                            wake_cnt_q <= WakeLoad;
                        end
                    end
                end
                StWake: begin
                    // Wake always runs to completion, even if requests drop.
                    if (wake_cnt_q == '0) begin
                        state_q <= StOn;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - WakeW'(1);
                    end
                end
                StOn: begin
                    if (!any_req) begin
                        if (IdleCycles == 0) begin
                            state_q <= StOff;
                            en_q    <= 1'b0;
                        end else begin
                            state_q    <= StIdle;
                            idle_cnt_q <= IdleLoad;
                        end
                    end
                end
                StIdle: begin
                    // A new request beats an expiring hysteresis.
                    if (any_req) begin
                        state_q <= StOn;
                    end else if (idle_cnt_q == '0) begin
                        state_q <= StOff;
                        en_q    <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q - IdleW'(1);
                    end
                end
                default: begin
                    state_q <= StOff;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    // Acks and enable derive from registered state; test_en bypasses the FSM.
    assign ack_o    = (state_q == StOn) ? req_i : '0;
    assign en_o     = en_q | test_en_i;
    assign active_o = (state_q != StOff);

`ifdef CLKGATE_STATS_EN
    logic [CntW-1:0] gated_q;

    // Saturating count of cycles with the gate closed; clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gated_q <= '0;
        end else if (stats_clr_i) begin
            gated_q <= '0;
        end else if (!en_o && (gated_q != '1)) begin
            gated_q <= gated_q + CntW'(1);
        end
    end

    assign gated_cycles_o = gated_q;
`endif

endmodule

// File: tb/tb_ibex_clkgate_ctrl.sv
// Self-checking bench for ibex_clkgate_ctrl: directed scenarios plus random
// request bursts, checked against a timestamp-based reference model.
module tb_ibex_clkgate_ctrl;

    localparam int NREQ = 4;
    localparam int WAKE = 2;
    localparam int IDLE = 8;
`ifdef CLKGATE_STATS_EN
    localparam int CNTW = 4;
`endif

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NREQ-1:0] req_i = '0;
    logic [NREQ-1:0] ack_o;
    logic            test_en_i = 1'b0;
    logic            en_o;
    logic            active_o;
`ifdef CLKGATE_STATS_EN
    logic            stats_clr_i = 1'b0;
    logic [CNTW-1:0] gated_cycles_o;
`endif

    ibex_clkgate_ctrl #(
        .NumReq     (NREQ),
        .WakeCycles (WAKE),
        .IdleCycles (IDLE)
`ifdef CLKGATE_STATS_EN
        ,
        .CntW       (CNTW)
`endif
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .ack_o     (ack_o),
        .test_en_i (test_en_i),
        .en_o      (en_o),
        .active_o  (active_o)
`ifdef CLKGATE_STATS_EN
        ,
        .stats_clr_i    (stats_clr_i),
        .gated_cycles_o (gated_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_total = 0;

    // Reference model in terms of timestamps:
    //   gate opens the cycle after a request seen while closed,
    //   acks are available from m_ready onward while the previous cycle was busy,
    //   gate closes IDLE+2 cycles after the last busy cycle at/after m_ready.
    int cyc = 0;
    bit m_gate = 0;
    int m_ready = 0;
    int m_last_busy = 0;
    int m_gated = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    endtask

    // One cycle: drive at the falling edge, check mid-cycle, update model at the rising edge.
    task automatic step(input logic [NREQ-1:0] r, input logic t);
        bit              any;
        logic            e_en;
        logic            e_act;
        logic [NREQ-1:0] e_ack;
        bit              clr;
        req_i     = r;
        test_en_i = t;
        #1;
        any = (r != '0) || t;
        if (m_gate && (cyc >= m_last_busy + IDLE + 2)) m_gate = 0;
        if (!m_gate) begin
            e_en = t; e_act = 1'b0; e_ack = '0;
        end else if (cyc < m_ready) begin
            e_en = 1'b1; e_act = 1'b1; e_ack = '0;
        end else begin
            e_en = 1'b1; e_act = 1'b1;
            e_ack = (m_last_busy == cyc - 1) ? r : '0;
        end
        chk("en_o", 32'(en_o), 32'(e_en));
        chk("active_o", 32'(active_o), 32'(e_act));
        chk("ack_o", 32'(ack_o), 32'(e_ack));
        clr = 0;
`ifdef CLKGATE_STATS_EN
        chk("gated_cycles_o", 32'(gated_cycles_o), 32'(m_gated));
        clr = stats_clr_i;
`endif
        @(posedge clk_i);
        if (!m_gate) begin
            if (any) begin
                m_gate      = 1;
                m_ready     = cyc + 1 + WAKE;
                m_last_busy = m_ready - 1;
            end
        end else if (cyc >= m_ready && any) begin
            m_last_busy = cyc;
        end
        if (clr) m_gated = 0;
        else if (!e_en && m_gated < (1 << 4) - 1) m_gated++;
        cyc++;
        @(negedge clk_i);
    endtask

    // Steps with no request until the gate closes; returns cycles taken (bounded).
    task automatic run_to_close(output int n);
        n = 0;
        while (en_o === 1'b1 && n < 40) begin
            step('0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [NREQ-1:0] r;
        logic t;
        int len;

        // Reset phase
        @(negedge clk_i);
        chk("rst_en_o", 32'(en_o), 32'd0);
        chk("rst_ack_o", 32'(ack_o), 32'd0);
        chk("rst_active_o", 32'(active_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Five idle cycles
        repeat (5) step('0, 1'b0);
`ifdef CLKGATE_STATS_EN
        chk("gated_after_5", 32'(gated_cycles_o), 32'd5);
`endif

        // Single requester: open, ack, release, close after hysteresis
        repeat (5) step(4'b0001, 1'b0);
        run_to_close(n);
        chk("close_latency_single", 32'(n), 32'd9);

        // Re-request during IDLE with idle_cnt at 3: ack next cycle, no wake delay
        repeat (5) step(4'b0001, 1'b0);
        repeat (5) step('0, 1'b0);
        step(4'b0100, 1'b0);
        chk("idle_rereq_ack", 32'(ack_o), 32'(4'b0100));
        step(4'b0100, 1'b0);
        run_to_close(n);
        chk("close_latency_rereq", 32'(n), 32'd9);

        // All requesters together, dropping one at a time
        repeat (4) step(4'b1111, 1'b0);
        chk("all_ack", 32'(ack_o), 32'(4'b1111));
        repeat (3) step(4'b1110, 1'b0);
        repeat (3) step(4'b1100, 1'b0);
        repeat (3) step(4'b1000, 1'b0);
        run_to_close(n);
        chk("close_latency_last_drop", 32'(n), 32'd9);

        // DFT force-on while OFF
        repeat (6) step('0, 1'b1);
        chk("test_en_active", 32'(active_o), 32'd1);
        run_to_close(n);
        chk("close_latency_test_en", 32'(n), 32'd9);

        // Random request bursts, including early withdrawals and test_en
        repeat (40) begin
            r   = ($urandom_range(0, 9) < 4) ? '0 : NREQ'($urandom_range(1, 15));
            t   = ($urandom_range(0, 9) == 0);
            len = $urandom_range(1, 12);
            repeat (len) step(r, t);
        end
        run_to_close(n);
        chk("random_closes", 32'(en_o), 32'd0);

`ifdef CLKGATE_STATS_EN
        // Saturate the statistics counter, then clear it
        repeat (20) step('0, 1'b0);
        chk("gated_saturated", 32'(gated_cycles_o), 32'd15);
        stats_clr_i = 1'b1;
        step('0, 1'b0);
        stats_clr_i = 1'b0;
        chk("gated_cleared", 32'(gated_cycles_o), 32'd0);
        step('0, 1'b0);
`endif

        // Reset asserted during WAKE takes effect without a clock edge
        step(4'b0010, 1'b0);
        chk("wake_en_before_rst", 32'(en_o), 32'd1);
        chk("wake_active_before_rst", 32'(active_o), 32'd1);
        req_i  = '0;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_en_o", 32'(en_o), 32'd0);
        chk("async_rst_active_o", 32'(active_o), 32'd0);
        chk("async_rst_ack_o", 32'(ack_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        cyc    = cyc + 1;
        m_gate = 0;
        m_gated = 0;
        rst_ni = 1'b1;

        // Normal operation resumes after reset
        repeat (4) step(4'b1000, 1'b0);
        chk("post_rst_ack", 32'(ack_o), 32'(4'b1000));
        run_to_close(n);
        chk("post_rst_close", 32'(n), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
